free_addr_mgr: RTL
==================

// Module: free_addr_mgr
// PURPOSE
//  Free-block address manager feeding the ingress unpack stage: supplies empty 12-bit buffer
//  block addresses over a valid/ready handshake (iEptyAddr/iEptyAddrVld/oEptyAddrRcvRdy on Unpack).
//  Accepts addresses returned by the egress/dequeue side after a block is read out.
//  Internally a circular FIFO of free addresses, self-initialised with 0..DEPTH-1 after reset.
// PARAMETERS
//  ADDR_W   12            block address width; DEPTH = 2**ADDR_W entries (4096 blocks)
// PORTS
//  iClk          in   1         clock; all state on rising edge
//  iRst_n        in   1         reset, asynchronous assert, active-low
//  oEptyAddr     out  ADDR_W    head free address offered to Unpack
//  oEptyAddrVld  out  1         oEptyAddr valid
//  iEptyAddrRdy  in   1         Unpack accepts (Unpack oEptyAddrRcvRdy)
//  iFreeAddr     in   ADDR_W    address being returned to free pool
//  iFreeAddrVld  in   1         iFreeAddr valid
//  oFreeAddrRdy  out  1         pool can accept a returned address
//  oFreeCnt      out  ADDR_W+1  number of addresses currently in pool (0..DEPTH)
//  oInitDone     out  1         initial fill complete
// BEHAVIOUR
//  - Reset (iRst_n=0, async): oEptyAddrVld=0, oEptyAddr=0, oFreeAddrRdy=0, oFreeCnt=0, oInitDone=0;
//    rd_ptr=wr_ptr=0; FSM -> INIT. Reset mid-operation discards pool contents; init restarts from 0.
//  - FSM: INIT -> RUN. INIT: init counter k writes mem[k]=k, wr_ptr++, oFreeCnt++ each cycle, k=0..DEPTH-1.
//    After DEPTH cycles: oFreeCnt=DEPTH, wr_ptr wraps to 0, oInitDone=1 (registered), state RUN. No exit from RUN except reset.
//  - In INIT: oEptyAddrVld=0 and oFreeAddrRdy=0; iFreeAddrVld and iEptyAddrRdy ignored.
//  - RUN pop: oEptyAddrVld = (oFreeCnt!=0); oEptyAddr = mem[rd_ptr] (comb read of register array).
//    Transfer when oEptyAddrVld && iEptyAddrRdy at posedge: rd_ptr++ (mod DEPTH), count--.
//    oEptyAddr/oEptyAddrVld stay stable while Vld=1 and Rdy=0.
//  - RUN push: oFreeAddrRdy = (oFreeCnt != DEPTH), from registered state only (no comb path from iEptyAddrRdy).
//    Transfer when iFreeAddrVld && oFreeAddrRdy: mem[wr_ptr]=iFreeAddr, wr_ptr++ (mod DEPTH), count++.
//  - Simultaneous push and pop in one cycle: both pointers advance, oFreeCnt unchanged.
//  - Empty (cnt=0): Vld=0; a pushed address is presented on oEptyAddr with Vld=1 the cycle after acceptance
//    (1-cycle push->pop latency); no same-cycle bypass.
//  - Full (cnt=DEPTH): oFreeAddrRdy=0; a pop that cycle re-enables Rdy next cycle.
//  - Pointers ADDR_W bits, natural wrap; count ADDR_W+1 bits; count never exceeds DEPTH or underflows.
//  - FIFO order strict: addresses leave in the order they entered. No duplicate-address check; upstream guarantees unique returns.
// TESTING
//  T1 reset release, ADDR_W=12 -> oInitDone=1 exactly 4096 cycles later; oFreeCnt=4096; first pops give 0x000,0x001,0x002.
//  T2 after init, iEptyAddrRdy=1 continuously -> 4096 transfers, addresses 0..4095 in order; then Vld=0, oFreeCnt=0.
//  T3 pool empty, push 0x5A3 -> next cycle oEptyAddrVld=1, oEptyAddr=0x5A3, oFreeCnt=1; pop -> cnt=0, Vld=0.
//  T4 ADDR_W=4, after init cnt=16 -> oFreeAddrRdy=0, push held off; one pop -> Rdy=1 next cycle, cnt=15.
//  T5 cnt=10, push 0x7FF and pop same cycle -> cnt stays 10; 0x7FF emerges after the 10 older entries.
//  T6 iRst_n low mid-drain (cnt=2000) -> all outputs reset values immediately; on release init refills, first pop 0x000.
//  Random: rdy/vld randomised both sides, 10k cycles; scoreboard model checks order, count, no loss/duplication.

Source files
------------

// File: rtl/free_addr_mgr.sv
// free_addr_mgr: pool of free buffer-block addresses for the ingress unpack stage.
// After reset the pool fills itself with 0..DEPTH-1, one address per cycle.
// From then on it runs as a circular FIFO:
//  - the Unpack side pops free addresses over a valid/ready handshake;
//  - the egress side pushes back the addresses of blocks it has read out.
module free_addr_mgr #(
  parameter int ADDR_W = 12
) (
  input  logic              iClk,
  input  logic              iRst_n,
  output logic [ADDR_W-1:0] oEptyAddr,
  output logic              oEptyAddrVld,
  input  logic              iEptyAddrRdy,
  input  logic [ADDR_W-1:0] iFreeAddr,
  input  logic              iFreeAddrVld,
  output logic              oFreeAddrRdy,
  output logic [ADDR_W:0]   oFreeCnt,
  output logic              oInitDone
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   FULL_CNT  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {
    INIT,
    RUN
  } stateT;

  stateT             state;
  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [ADDR_W-1:0] rdPtr;
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W:0]   freeCnt;
  logic [ADDR_W:0]   cntNext;
  logic              eptyVld;
  logic              freeRdy;
  logic              initDone;
  logic              popFire;
  logic              pushFire;
  logic              memWe;
  logic [ADDR_W-1:0] memWdata;

  // Handshake decode and next occupancy. The ready/valid flags used here are
  // registered, so neither side's input can combinationally reach the other's output.
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    popFire  = 1'b0;
    pushFire = 1'b0;
    cntNext  = freeCnt;
    memWe    = 1'b0;
    memWdata = iFreeAddr;
    if (state == RUN) begin
      popFire  = eptyVld && iEptyAddrRdy;
      pushFire = freeRdy && iFreeAddrVld;
      memWe    = pushFire;
      if (pushFire && !popFire) begin
        cntNext = freeCnt + 1'b1;
      end else if (popFire && !pushFire) begin
        cntNext = freeCnt - 1'b1;
      end
    end else begin
      // During INIT the write pointer doubles as the fill counter: slot k holds k.
      memWe    = 1'b1;
      memWdata = wrPtr;
    end
  end

  // Control FSM: INIT fills the pool once, RUN serves pops and pushes until the next reset.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state    <= INIT;
      rdPtr    <= '0;
      wrPtr    <= '0;
      freeCnt  <= '0;
      eptyVld  <= 1'b0;
      freeRdy  <= 1'b0;
      initDone <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      case (state)
        INIT: begin
          wrPtr   <= wrPtr + 1'b1;
          freeCnt <= freeCnt + 1'b1;
          if (wrPtr == LAST_ADDR) begin
            // Last fill slot: pool is full, wrPtr wraps to 0, start offering addresses.
            state    <= RUN;
            initDone <= 1'b1;
            eptyVld  <= 1'b1;
            freeRdy  <= 1'b0;
          end
        end
        RUN: begin
          if (popFire) begin
            rdPtr <= rdPtr + 1'b1;
          end
          if (pushFire) begin
            wrPtr <= wrPtr + 1'b1;
          end
          freeCnt <= cntNext;
          eptyVld <= (cntNext != '0);
          freeRdy <= (cntNext != FULL_CNT);
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // Address storage: written by the initial fill and by accepted returns.
  // NOTE: the array has no reset; INIT rewrites every slot before any of it is read.
  always_ff @(posedge iClk) begin
    if (memWe) begin
      addrMem[wrPtr] <= memWdata;
    end
  end

  // The head entry is shown only while valid, so the address bus reads 0 in reset and INIT.
  assign oEptyAddr    = eptyVld ? addrMem[rdPtr] : '0;
  assign oEptyAddrVld = eptyVld;
  assign oFreeAddrRdy = freeRdy;
  assign oFreeCnt     = freeCnt;
  assign oInitDone    = initDone;

endmodule
